control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_pkg.sv | 49 ++++
 rtl/control_unit_if.sv | 33 +++
 rtl/cond_check.sv | 40 ++++
 rtl/control_unit.sv | 135 +++++++++++++
 tb/tb_control_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the control unit: condition codes, op classes,
// ALU-control encodings, FSM state enum and flag bit positions.
package control_pkg;

    // ARM condition codes (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;  // used as the HALT request

    // Instruction classes (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // ALU-control encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_CMP = 4'b1010;

    // Flag bit positions within alu_flags / flags_q
    localparam int unsigned FLAG_V   = 0;
    localparam int unsigned FLAG_C   = 1;
    localparam int unsigned FLAG_Z   = 2;
    localparam int unsigned FLAG_N   = 3;
    localparam int unsigned FLAG_AUX = 4;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

endpackage

// File: rtl/control_unit_if.sv
// Instruction-field / datapath-control bundle between the instruction source
// (master) and the control unit (slave).
interface control_unit_if;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [4:0] alu_flags;

    logic       pc_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_control;
    logic [1:0] reg_src;
    logic [4:0] flags_q;
    logic       halted;

    modport master (
        output cond, op, funct, rd, alu_flags,
        input  pc_src, mem_to_reg, mem_write, alu_src, reg_write,
               alu_control, reg_src, flags_q, halted
    );

    modport slave (
        input  cond, op, funct, rd, alu_flags,
        output pc_src, mem_to_reg, mem_write, alu_src, reg_write,
               alu_control, reg_src, flags_q, halted
    );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against the NZCV flags.
module cond_check
    import control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Condition table; 1111 never passes so it can serve as HALT
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Control unit: START/RUN/HALT FSM, combinational instruction decode,
// condition gating and flag register.
// Optional feature: define CONTROL_UNIT_PERF_CNT_EN to add the
// retired_count output (count of condition-passing RUN instructions).
module control_unit
    import control_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    control_unit_if.slave      bus
`ifdef CONTROL_UNIT_PERF_CNT_EN
    ,
    output logic [31:0]        retired_count
`endif
);

    state_e      state_q, state_d;
    logic [4:0]  flags_q, flags_d;

    logic        cond_pass;
    logic        active;

    logic        dec_pc_src;
    logic        dec_mem_to_reg;
    logic        dec_mem_write;
    logic        dec_alu_src;
    logic        dec_reg_write;
    logic [3:0]  dec_alu_control;
    logic [1:0]  dec_reg_src;
    logic        dec_flag_write;
    logic        flag_write;

    cond_check u_cond_check (
        .cond  (bus.cond),
        .flags (flags_q[3:0]),
        .pass  (cond_pass)
    );

    // Writes are only allowed in RUN with a passing condition
    assign active = (state_q == ST_RUN) && cond_pass;

    // Instruction decode into ungated control values
    always_comb begin
        dec_pc_src      = 1'b0;
        dec_mem_to_reg  = 1'b0;
        dec_mem_write   = 1'b0;
        dec_alu_src     = 1'b0;
        dec_reg_write   = 1'b0;
        dec_alu_control = ALU_AND;
        dec_reg_src     = 2'b00;
        dec_flag_write  = 1'b0;
        case (bus.op)
            OP_DP: begin
                dec_alu_control = bus.funct[4:1];
                dec_alu_src     = bus.funct[5];
                dec_reg_src     = bus.funct[5] ? 2'b10 : 2'b00;
                dec_reg_write   = (bus.funct[4:1] != ALU_CMP);
                dec_flag_write  = bus.funct[0] | (bus.funct[4:1] == ALU_CMP);
            end
            OP_MEM: begin
                dec_alu_src     = 1'b1;
                dec_alu_control = bus.funct[3] ? ALU_ADD : ALU_SUB;
                dec_reg_src     = 2'b10;
                dec_reg_write   = bus.funct[0];
                dec_mem_to_reg  = bus.funct[0];
                dec_mem_write   = ~bus.funct[0];
            end
            OP_BR: begin
                dec_pc_src      = 1'b1;
                dec_alu_src     = 1'b1;
                dec_alu_control = ALU_ADD;
                dec_reg_src     = 2'b01;
            end
            default: ;
        endcase
    end

    // Gate write enables by FSM state and condition; Rd=PC also redirects PC
    always_comb begin
        bus.reg_write   = active & dec_reg_write;
        bus.mem_write   = active & dec_mem_write;
        bus.pc_src      = active & (dec_pc_src | (dec_reg_write & (bus.rd == 4'hF)));
        bus.mem_to_reg  = dec_mem_to_reg;
        bus.alu_src     = dec_alu_src;
        bus.alu_control = dec_alu_control;
        bus.reg_src     = dec_reg_src;
        bus.flags_q     = flags_q;
        bus.halted      = (state_q == ST_HALT);
    end

    assign flag_write = active & dec_flag_write;

    // Next-state and flag-register next value
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (bus.cond == COND_NV) state_d = ST_HALT;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_START;
        endcase
        if (flag_write) flags_d = bus.alu_flags;
    end

    // State and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_START;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

`ifdef CONTROL_UNIT_PERF_CNT_EN
    logic [31:0] retired_count_q, retired_count_d;

    // Retired-instruction count; wraps naturally at 32 bits
    always_comb begin
        retired_count_d = retired_count_q;
        if (active) retired_count_d = retired_count_q + 32'd1;
    end

    // Retired-instruction counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_count_q <= '0;
        else     retired_count_q <= retired_count_d;
    end

    assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven RUN vectors through a
// scoreboard queue plus hand sequences for reset, START, HALT and the
// optional CONTROL_UNIT_PERF_CNT_EN counter.
module tb_control_unit;
    import control_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_unit_if bus();

`ifdef CONTROL_UNIT_PERF_CNT_EN
    logic [31:0] retired_count;
`endif

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef CONTROL_UNIT_PERF_CNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    typedef struct {
        string      name;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [4:0] alu_flags;
        logic [16:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [16:0] outs(input logic pc, input logic m2r, input logic mw,
                                         input logic as, input logic rw, input logic [3:0] ac,
                                         input logic [1:0] rs, input logic [4:0] fq,
                                         input logic h);
        return {pc, m2r, mw, as, rw, ac, rs, fq, h};
    endfunction

    function automatic logic [16:0] dut_outs();
        return {bus.pc_src, bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write,
                bus.alu_control, bus.reg_src, bus.flags_q, bus.halted};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [4:0] af);
        bus.cond      = c;
        bus.op        = o;
        bus.funct     = f;
        bus.rd        = r;
        bus.alu_flags = af;
    endtask

    task automatic add_vec(input string n, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input logic [4:0] af,
                           input logic [16:0] e);
        vec_t v;
        v.name = n; v.cond = c; v.op = o; v.funct = f; v.rd = r; v.alu_flags = af; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, cond, op, funct, rd, alu_flags, outs(pc,m2r,mw,as,rw,ac,rs,flags_q,halted)
        add_vec("al_add_imm",   4'hE, 2'b00, 6'b101000, 4'h0, 5'b00000, outs(0,0,0,1,1,4'h4,2'b10,5'b00000,0));
        add_vec("subs",         4'hE, 2'b00, 6'b000101, 4'h1, 5'b00100, outs(0,0,0,0,1,4'h2,2'b00,5'b00000,0));
        add_vec("eq_add",       4'h0, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,1,4'h4,2'b00,5'b00100,0));
        add_vec("ne_add",       4'h1, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,0,4'h4,2'b00,5'b00100,0));
        add_vec("cmp",          4'hE, 2'b00, 6'b010100, 4'h0, 5'b01000, outs(0,0,0,0,0,4'hA,2'b00,5'b00100,0));
        add_vec("mi_add",       4'h4, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,1,4'h4,2'b00,5'b01000,0));
        add_vec("ge_add",       4'hA, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,0,4'h4,2'b00,5'b01000,0));
        add_vec("lt_add",       4'hB, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,1,4'h4,2'b00,5'b01000,0));
        add_vec("eq_adds_fail", 4'h0, 2'b00, 6'b001001, 4'h2, 5'b00011, outs(0,0,0,0,0,4'h4,2'b00,5'b01000,0));
        add_vec("al_adds",      4'hE, 2'b00, 6'b001001, 4'h2, 5'b10010, outs(0,0,0,0,1,4'h4,2'b00,5'b01000,0));
        add_vec("hi_add",       4'h8, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,1,4'h4,2'b00,5'b10010,0));
        add_vec("ls_add",       4'h9, 2'b00, 6'b001000, 4'h2, 5'b00000, outs(0,0,0,0,0,4'h4,2'b00,5'b10010,0));
        add_vec("str",          4'hE, 2'b01, 6'b011000, 4'h3, 5'b00000, outs(0,0,1,1,0,4'h4,2'b10,5'b10010,0));
        add_vec("ldr",          4'hE, 2'b01, 6'b011001, 4'h3, 5'b00000, outs(0,1,0,1,1,4'h4,2'b10,5'b10010,0));
        add_vec("ldr_sub",      4'hE, 2'b01, 6'b010001, 4'h3, 5'b00000, outs(0,1,0,1,1,4'h2,2'b10,5'b10010,0));
        add_vec("branch",       4'hE, 2'b10, 6'b000000, 4'h0, 5'b00000, outs(1,0,0,1,0,4'h4,2'b01,5'b10010,0));
        add_vec("branch_fail",  4'h0, 2'b10, 6'b000000, 4'h0, 5'b00000, outs(0,0,0,1,0,4'h4,2'b01,5'b10010,0));
        add_vec("add_rd_pc",    4'hE, 2'b00, 6'b001000, 4'hF, 5'b00000, outs(1,0,0,0,1,4'h4,2'b00,5'b10010,0));
        add_vec("nop",          4'hE, 2'b11, 6'b111111, 4'hF, 5'b00000, outs(0,0,0,0,0,4'h0,2'b00,5'b10010,0));
        add_vec("gt_and",       4'hC, 2'b00, 6'b000000, 4'h1, 5'b00000, outs(0,0,0,0,1,4'h0,2'b00,5'b10010,0));
        add_vec("le_orr_fail",  4'hD, 2'b00, 6'b011000, 4'h1, 5'b00000, outs(0,0,0,0,0,4'hC,2'b00,5'b10010,0));

        // Reset state
        rst = 1'b1;
        drive(4'hE, 2'b00, 6'b101000, 4'h0, 5'b00000);
        step();
        step();
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_flags_q",   32'(bus.flags_q),   32'd0);
        check("rst_halted",    32'(bus.halted),    32'd0);
        rst = 1'b0;

        // START cycle: no writes even though AL ADD is presented
        @(negedge clk);
        check("start_reg_write", 32'(bus.reg_write), 32'd0);
        check("start_pc_src",    32'(bus.pc_src),    32'd0);
        step();

        // RUN vectors through the scoreboard
        foreach (vecs[i]) begin
            sb_t e;
            drive(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].alu_flags);
            e.name = vecs[i].name;
            e.exp  = vecs[i].exp;
            sbq.push_back(e);
            @(negedge clk);
            if (sbq.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                sb_t got_e;
                got_e = sbq.pop_front();
                check(got_e.name, 32'(dut_outs()), 32'(got_e.exp));
            end
            step();
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);

        // HALT entry on cond=1111
        drive(4'hF, 2'b00, 6'b001001, 4'h2, 5'b11111);
        @(negedge clk);
        check("nv_reg_write", 32'(bus.reg_write), 32'd0);
        check("nv_halted_pre", 32'(bus.halted), 32'd0);
        step();
        check("halted", 32'(bus.halted), 32'd1);
        check("halt_flags_hold", 32'(bus.flags_q), 32'b10010);
        drive(4'hE, 2'b00, 6'b001000, 4'h2, 5'b00000);
        @(negedge clk);
        check("halt_add_reg_write", 32'(bus.reg_write), 32'd0);
        check("halt_sticky", 32'(bus.halted), 32'd1);

        // Async reset mid-cycle, no clock edge in between
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_halted", 32'(bus.halted),  32'd0);
        check("async_rst_flags",  32'(bus.flags_q), 32'd0);
        step();
        rst = 1'b0;
        step();  // START -> RUN

        // Reset mid-instruction drops the write enable at once
        drive(4'hE, 2'b00, 6'b001000, 4'h2, 5'b00000);
        @(negedge clk);
        check("run_reg_write", 32'(bus.reg_write), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_reg_write", 32'(bus.reg_write), 32'd0);
        step();
        rst = 1'b0;

`ifdef CONTROL_UNIT_PERF_CNT_EN
        check("cnt_reset", retired_count, 32'd0);
        step();  // START, not counted
        for (int i = 0; i < 3; i++) begin
            drive(4'hE, 2'b00, 6'b001000, 4'h2, 5'b00000);
            step();
        end
        drive(4'h0, 2'b00, 6'b001000, 4'h2, 5'b00000);  // EQ with Z=0 fails
        step();
        check("cnt_three", retired_count, 32'd3);
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        check("cnt_preload", retired_count, 32'hFFFF_FFFF);
        drive(4'hE, 2'b00, 6'b001000, 4'h2, 5'b00000);
        step();
        check("cnt_wrap", retired_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
